// File: rtl/core_sequencer_if.sv
// Stage handshake bundle between the core sequencer and its five pipeline stages.
// The sequencer drives one-cycle enables, and each stage answers with a done pulse.
interface core_sequencer_if;
    logic       fetch_enable;
    logic       fetch_done;
    logic       decode_enable;
    logic       decode_done;
    logic [5:0] exec_command;
    logic       exec_enable;
    logic       exec_done;
    logic       mem_enable;
    logic       mem_done;
    logic       write_enable;
    logic       write_done;

    modport master (
        output fetch_enable, decode_enable, exec_enable, mem_enable, write_enable,
        input  fetch_done, decode_done, exec_done, mem_done, write_done, exec_command
    );

    modport slave (
        input  fetch_enable, decode_enable, exec_enable, mem_enable, write_enable,
        output fetch_done, decode_done, exec_done, mem_done, write_done, exec_command
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/exec/mem/write stage control,
// with an opcode-driven stage path, retire/cycle counters, halt, and a stage watchdog.
module core_sequencer #(
    parameter logic [5:0]  HALT_OP = 6'b111111,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CW      = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    clear,
    core_sequencer_if.master        bus,
    output logic [2:0]              state,
    output logic                    halted,
    output logic                    error,
    output logic [2:0]              err_stage,
    output logic [CW-1:0]           instr_count,
    output logic [CW-1:0]           cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t          r_state;
    state_t          w_next;
    logic [5:0]      r_op_q;
    logic [WW-1:0]   r_wait;
    logic [WW-1:0]   w_wait_next;
    logic            r_fetch_en, r_decode_en, r_exec_en, r_mem_en, r_write_en;
    logic            w_fetch_en, w_decode_en, w_exec_en, w_mem_en, w_write_en;
    logic            r_halted, r_error;
    logic [2:0]      r_err_stage;
    logic [CW-1:0]   r_instr_count, r_cycle_count;
    logic            w_done, w_stage, w_timeout, w_retire, w_clear;

    // A done raised during the stage's own enable cycle is deliberately discarded.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_done = 1'b0;
        case (r_state)
            S_FETCH:  w_done = bus.fetch_done  && !r_fetch_en;
            S_DECODE: w_done = bus.decode_done && !r_decode_en;
            S_EXEC:   w_done = bus.exec_done   && !r_exec_en;
            S_MEM:    w_done = bus.mem_done    && !r_mem_en;
            S_WB:     w_done = bus.write_done  && !r_write_en;
            default:  w_done = 1'b0;
        endcase
    end

    assign w_stage   = (r_state >= S_FETCH) && (r_state <= S_WB);
    assign w_timeout = (TIMEOUT != 0) && w_stage && !w_done && (r_wait == WW'(TIMEOUT));
    assign w_clear   = clear && ((r_state == S_HALT) || (r_state == S_ERR));

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        if (w_timeout) begin
            w_next = S_ERR;
        end else begin
            case (r_state)
                S_IDLE:   if (start)  w_next = S_FETCH;
                S_FETCH:  if (w_done) w_next = S_DECODE;
                S_DECODE: if (w_done) w_next = (bus.exec_command == HALT_OP) ? S_HALT : S_EXEC;
                S_EXEC: begin
                    if (w_done) begin
                        if (r_op_q[5:4] == 2'b10)
                            w_next = S_MEM;
                        else if (r_op_q == 6'b000010 || r_op_q == 6'b000100 || r_op_q == 6'b000101)
                            w_next = S_FETCH;
                        else
                            w_next = S_WB;
                    end
                end
                S_MEM:    if (w_done) w_next = r_op_q[3] ? S_FETCH : S_WB;
                S_WB:     if (w_done) w_next = S_FETCH;
                S_HALT,
                S_ERR:    if (clear)  w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Output logic: enables pulse only on entry; a completed stage going to FETCH retires.
    always_comb begin
        w_fetch_en  = (w_next == S_FETCH)  && (r_state != S_FETCH);
        w_decode_en = (w_next == S_DECODE) && (r_state != S_DECODE);
        w_exec_en   = (w_next == S_EXEC)   && (r_state != S_EXEC);
        w_mem_en    = (w_next == S_MEM)    && (r_state != S_MEM);
        w_write_en  = (w_next == S_WB)     && (r_state != S_WB);
        w_retire    = w_done && (w_next == S_FETCH);
        w_wait_next = r_wait;
        if (w_next != r_state)
            w_wait_next = '0;
        else if (w_stage && !w_done && (TIMEOUT != 0))
            w_wait_next = r_wait + WW'(1);
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_op_q        <= '0;
            r_wait        <= '0;
            r_fetch_en    <= 1'b0;
            r_decode_en   <= 1'b0;
            r_exec_en     <= 1'b0;
            r_mem_en      <= 1'b0;
            r_write_en    <= 1'b0;
            r_halted      <= 1'b0;
            r_error       <= 1'b0;
            r_err_stage   <= '0;
            r_instr_count <= '0;
            r_cycle_count <= '0;
        end else begin
            r_state     <= w_next;
            r_wait      <= w_wait_next;
            r_fetch_en  <= w_fetch_en;
            r_decode_en <= w_decode_en;
            r_exec_en   <= w_exec_en;
            r_mem_en    <= w_mem_en;
            r_write_en  <= w_write_en;
            r_halted    <= (w_next == S_HALT);
            r_error     <= (w_next == S_ERR);
            if (r_state == S_DECODE && w_done)
                r_op_q <= bus.exec_command;
            if (w_timeout)
                r_err_stage <= r_state;
            else if (w_clear)
                r_err_stage <= '0;
            if (w_clear) begin
                r_instr_count <= '0;
                r_cycle_count <= '0;
            end else begin
                if (w_retire) r_instr_count <= r_instr_count + CW'(1);
                if (w_stage)  r_cycle_count <= r_cycle_count + CW'(1);
            end
        end
    end

    assign bus.fetch_enable  = r_fetch_en;
    assign bus.decode_enable = r_decode_en;
    assign bus.exec_enable   = r_exec_en;
    assign bus.mem_enable    = r_mem_en;
    assign bus.write_enable  = r_write_en;
    assign state             = r_state;
    assign halted            = r_halted;
    assign error             = r_error;
    assign err_stage         = r_err_stage;
    assign instr_count       = r_instr_count;
    assign cycle_count       = r_cycle_count;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: each stage answers done two cycles after its enable,
// and every expected value is worked out by hand from the stage timing.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        clear;
    logic [2:0]  state;
    logic        halted;
    logic        error;
    logic [2:0]  err_stage;
    logic [31:0] instr_count;
    logic [31:0] cycle_count;
    logic [4:0]  w_en;
    int          n_total = 0;
    int          n_pass  = 0;

    core_sequencer_if bus();

    core_sequencer #(.HALT_OP(6'b111111), .TIMEOUT(8), .CW(32)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .clear       (clear),
        .bus         (bus.master),
        .state       (state),
        .halted      (halted),
        .error       (error),
        .err_stage   (err_stage),
        .instr_count (instr_count),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    assign w_en = {bus.write_enable, bus.mem_enable, bus.exec_enable, bus.decode_enable, bus.fetch_enable};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_done(input int idx, input logic val);
        case (idx)
            0: bus.fetch_done  = val;
            1: bus.decode_done = val;
            2: bus.exec_done   = val;
            3: bus.mem_done    = val;
            default: bus.write_done = val;
        endcase
    endtask

    // Called in a stage's enable cycle; raises done two cycles later, returns in the following cycle.
    task automatic finish_stage(input int idx, input logic [5:0] cmd);
        tick();
        tick();
        set_done(idx, 1'b1);
        bus.exec_command = cmd;
        tick();
        set_done(idx, 1'b0);
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1;
        n_total++; if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
        tick();
        tick();
        n_total++; if (w_en !== 5'b00000) $display("FAIL reset_enables: got %b want 00000", w_en); else n_pass++;
        n_total++; if ({halted, error, err_stage} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {halted, error, err_stage}); else n_pass++;
        n_total++; if (instr_count !== 32'd0) $display("FAIL reset_instr: got %0d want 0", instr_count); else n_pass++;
        n_total++; if (cycle_count !== 32'd0) $display("FAIL reset_cycle: got %0d want 0", cycle_count); else n_pass++;
        rstn = 1'b1;
        tick();
        n_total++; if (state !== 3'd0) $display("FAIL idle_hold: got %0d want 0", state); else n_pass++;
    endtask

    task automatic test_alu();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_total++; if (state !== 3'd1) $display("FAIL alu_fetch_state: got %0d want 1", state); else n_pass++;
        n_total++; if (w_en !== 5'b00001) $display("FAIL alu_fetch_en: got %b want 00001", w_en); else n_pass++;
        finish_stage(0, 6'b000000);
        n_total++; if (w_en !== 5'b00010) $display("FAIL alu_decode_en: got %b want 00010", w_en); else n_pass++;
        finish_stage(1, 6'b000000);
        n_total++; if (w_en !== 5'b00100) $display("FAIL alu_exec_en: got %b want 00100", w_en); else n_pass++;
        finish_stage(2, 6'b000000);
        n_total++; if (w_en !== 5'b10000) $display("FAIL alu_write_en: got %b want 10000", w_en); else n_pass++;
        finish_stage(4, 6'b000000);
        n_total++; if (w_en !== 5'b00001) $display("FAIL alu_next_fetch: got %b want 00001", w_en); else n_pass++;
        n_total++; if (instr_count !== 32'd1) $display("FAIL alu_instr: got %0d want 1", instr_count); else n_pass++;
        n_total++; if (cycle_count !== 32'd12) $display("FAIL alu_cycles: got %0d want 12", cycle_count); else n_pass++;
    endtask

    task automatic test_load_store();
        finish_stage(0, 6'b000000);
        finish_stage(1, 6'b100011);
        finish_stage(2, 6'b000000);
        n_total++; if (w_en !== 5'b01000) $display("FAIL load_mem_en: got %b want 01000", w_en); else n_pass++;
        finish_stage(3, 6'b000000);
        n_total++; if (w_en !== 5'b10000) $display("FAIL load_write_en: got %b want 10000", w_en); else n_pass++;
        finish_stage(4, 6'b000000);
        n_total++; if (instr_count !== 32'd2) $display("FAIL load_instr: got %0d want 2", instr_count); else n_pass++;
        finish_stage(0, 6'b000000);
        finish_stage(1, 6'b101011);
        finish_stage(2, 6'b000000);
        n_total++; if (w_en !== 5'b01000) $display("FAIL store_mem_en: got %b want 01000", w_en); else n_pass++;
        finish_stage(3, 6'b000000);
        n_total++; if (w_en !== 5'b00001) $display("FAIL store_to_fetch: got %b want 00001", w_en); else n_pass++;
        n_total++; if (instr_count !== 32'd3) $display("FAIL store_instr: got %0d want 3", instr_count); else n_pass++;
    endtask

    task automatic test_branch();
        finish_stage(0, 6'b000000);
        finish_stage(1, 6'b000100);
        finish_stage(2, 6'b000000);
        n_total++; if (w_en !== 5'b00001) $display("FAIL branch_to_fetch: got %b want 00001", w_en); else n_pass++;
        n_total++; if (state !== 3'd1) $display("FAIL branch_state: got %0d want 1", state); else n_pass++;
        n_total++; if (instr_count !== 32'd4) $display("FAIL branch_instr: got %0d want 4", instr_count); else n_pass++;
    endtask

    task automatic test_halt();
        finish_stage(0, 6'b000000);
        finish_stage(1, 6'b111111);
        n_total++; if (state !== 3'd6) $display("FAIL halt_state: got %0d want 6", state); else n_pass++;
        n_total++; if (halted !== 1'b1) $display("FAIL halt_flag: got %b want 1", halted); else n_pass++;
        n_total++; if (w_en !== 5'b00000) $display("FAIL halt_no_exec: got %b want 00000", w_en); else n_pass++;
        n_total++; if (instr_count !== 32'd4) $display("FAIL halt_instr: got %0d want 4", instr_count); else n_pass++;
        start = 1'b1;
        bus.exec_done = 1'b1;
        tick();
        start = 1'b0;
        bus.exec_done = 1'b0;
        n_total++; if (state !== 3'd6) $display("FAIL halt_ignores_start: got %0d want 6", state); else n_pass++;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_total++; if (state !== 3'd0) $display("FAIL clear_state: got %0d want 0", state); else n_pass++;
        n_total++; if (halted !== 1'b0) $display("FAIL clear_halted: got %b want 0", halted); else n_pass++;
        n_total++; if (instr_count !== 32'd0) $display("FAIL clear_instr: got %0d want 0", instr_count); else n_pass++;
        n_total++; if (cycle_count !== 32'd0) $display("FAIL clear_cycle: got %0d want 0", cycle_count); else n_pass++;
    endtask

    task automatic test_ignored_events();
        bus.fetch_done = 1'b1;
        bus.write_done = 1'b1;
        clear = 1'b1;
        tick();
        bus.fetch_done = 1'b0;
        bus.write_done = 1'b0;
        clear = 1'b0;
        n_total++; if (state !== 3'd0) $display("FAIL idle_ignores_done: got %0d want 0", state); else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.fetch_done = 1'b1;
        bus.mem_done = 1'b1;
        tick();
        bus.fetch_done = 1'b0;
        bus.mem_done = 1'b0;
        n_total++; if (state !== 3'd1) $display("FAIL done_in_enable_cycle: got %0d want 1", state); else n_pass++;
        n_total++; if (w_en !== 5'b00000) $display("FAIL enable_single_pulse: got %b want 00000", w_en); else n_pass++;
        tick();
        bus.fetch_done = 1'b1;
        tick();
        bus.fetch_done = 1'b0;
        n_total++; if (w_en !== 5'b00010) $display("FAIL late_fetch_done: got %b want 00010", w_en); else n_pass++;
        finish_stage(1, 6'b000000);
        n_total++; if (w_en !== 5'b00100) $display("FAIL pre_reset_exec_en: got %b want 00100", w_en); else n_pass++;
        tick();
        rstn = 1'b0;
        #1;
        n_total++; if (state !== 3'd0) $display("FAIL async_reset_state: got %0d want 0", state); else n_pass++;
        n_total++; if (cycle_count !== 32'd0) $display("FAIL async_reset_cycle: got %0d want 0", cycle_count); else n_pass++;
        n_total++; if ({w_en, halted, error} !== 7'b0) $display("FAIL async_reset_outputs: got %b want 0000000", {w_en, halted, error}); else n_pass++;
        rstn = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_total++; if (w_en !== 5'b00001 || state !== 3'd1) $display("FAIL restart_fetch: got en=%b state=%0d want en=00001 state=1", w_en, state); else n_pass++;
    endtask

    task automatic test_watchdog();
        finish_stage(0, 6'b000000);
        finish_stage(1, 6'b100011);
        finish_stage(2, 6'b000000);
        n_total++; if (w_en !== 5'b01000) $display("FAIL wd_mem_en: got %b want 01000", w_en); else n_pass++;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_total++; if (state !== 3'd4) $display("FAIL wd_waiting_%0d: got %0d want 4", i, state); else n_pass++;
        end
        tick();
        n_total++; if (state !== 3'd7) $display("FAIL wd_err_state: got %0d want 7", state); else n_pass++;
        n_total++; if (error !== 1'b1) $display("FAIL wd_error: got %b want 1", error); else n_pass++;
        n_total++; if (err_stage !== 3'd4) $display("FAIL wd_err_stage: got %0d want 4", err_stage); else n_pass++;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_total++; if ({state, error, err_stage} !== 7'b0) $display("FAIL wd_clear: got %b want 0000000", {state, error, err_stage}); else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_stage(0, 6'b000000);
        finish_stage(1, 6'b100011);
        finish_stage(2, 6'b000000);
        for (int i = 1; i <= 8; i++) tick();
        bus.mem_done = 1'b1;
        tick();
        bus.mem_done = 1'b0;
        n_total++; if (state !== 3'd5) $display("FAIL wd_done_wins_state: got %0d want 5", state); else n_pass++;
        n_total++; if (error !== 1'b0 || w_en !== 5'b10000) $display("FAIL wd_done_wins: got error=%b en=%b want error=0 en=10000", error, w_en); else n_pass++;
        finish_stage(4, 6'b000000);
        n_total++; if (instr_count !== 32'd1) $display("FAIL wd_retire: got %0d want 1", instr_count); else n_pass++;
    endtask

    initial begin
        rstn = 1'b1;
        start = 1'b0;
        clear = 1'b0;
        bus.fetch_done = 1'b0;
        bus.decode_done = 1'b0;
        bus.exec_done = 1'b0;
        bus.mem_done = 1'b0;
        bus.write_done = 1'b0;
        bus.exec_command = 6'b000000;
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_halt();
        test_ignored_events();
        test_watchdog();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle control FSM for the core.
- Steps each instruction through the fetch, decode, exec, mem and write stages.
- Issues a one-cycle enable pulse to each stage and waits for that stage's done pulse.
- Chooses the stage path from the decoded 6-bit opcode.
- Provides retire/cycle counters, a halt state and a per-stage watchdog.

Parameters:
- HALT_OP, 6'b111111, opcode that halts the core after decode.
- TIMEOUT, 1024, maximum wait cycles for a stage done; 0 disables the watchdog.
- CW, 32, width of the instr_count and cycle_count counters.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  in IDLE, begin execution.
- clear  input  1  in HALT or ERR, return to IDLE and zero the counters.
- fetch_enable  output  1  one-cycle start pulse to fetch.
- fetch_done  input  1  fetch complete.
- decode_enable  output  1  one-cycle start pulse to decode.
- decode_done  input  1  decode complete; exec_command is valid in this cycle.
- exec_command  input  6  opcode from decode.
- exec_enable  output  1  one-cycle start pulse to exec.
- exec_done  input  1  exec complete.
- mem_enable  output  1  one-cycle start pulse to the memory stage.
- mem_done  input  1  memory access complete.
- write_enable  output  1  one-cycle start pulse to register writeback.
- write_done  input  1  writeback complete.
- state  output  3  current FSM state encoding.
- halted  output  1  FSM is in HALT.
- error  output  1  FSM is in ERR.
- err_stage  output  3  state code of the stage that timed out.
- instr_count  output  CW  retired instructions.
- cycle_count  output  CW  cycles spent outside IDLE, HALT and ERR.

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
- Reset (rstn low, asynchronous): state=IDLE. All enables, halted, error, err_stage, instr_count, cycle_count and op_q are 0. A reset in mid-instruction abandons that instruction.
- All outputs are registered.
- Enable pulses:
  - X_enable goes high on the edge that enters stage state X, and is cleared on the next edge.
  - Each stage receives exactly one pulse per visit.
  - At most one enable is high in any cycle.
- Done sampling:
  - done is sampled only in the cycles after the enable cycle. A done coinciding with the enable cycle is ignored.
  - Minimum stage occupancy is 2 cycles. The next stage's enable is high in the cycle after done.
  - Done inputs of stages not currently active are ignored.
- Transitions:
  - IDLE: start -> FETCH.
  - FETCH: done -> DECODE.
  - DECODE: on done, latch op_q <= exec_command. Then:
    - exec_command==HALT_OP -> HALT.
    - Otherwise -> EXEC.
  - EXEC: on done, choose by op_q:
    - op_q[5:4]==2'b10 (load/store) -> MEM.
    - op_q is 6'b000010, 6'b000100 or 6'b000101 (j, beq, bne) -> FETCH, and the instruction retires.
    - Otherwise -> WB.
  - MEM: on done, op_q[3]==1 (store) -> FETCH and retire; else (load) -> WB.
  - WB: done -> FETCH and retire.
  - HALT, ERR: clear -> IDLE. Other inputs are ignored.
- Retire: instr_count increments by 1 on the retiring edge. HALT_OP does not retire.
- cycle_count increments each cycle the state is in 1..5. Both counters wrap modulo 2^CW.
- Watchdog:
  - A wait counter zeroes on stage entry and increments each stage cycle that has no done.
  - If the counter equals TIMEOUT and done is low, the next state is ERR, with err_stage=state and error=1.
  - If done arrives in the same cycle as the timeout, done wins.
- start in a non-IDLE state is ignored. clear in states other than HALT/ERR is ignored.
- clear zeroes instr_count, cycle_count, err_stage, error and halted.
- halted and error are high exactly while state==HALT or state==ERR, respectively.

Test Plan:
- ALU op: reset; start at cycle 0; each stage returns done 2 cycles after its enable; exec_command=6'b000000 -> enables in order fetch, decode, exec, write (no mem_enable); instr_count=1 after write_done; next fetch_enable in the cycle after write_done.
- Load: exec_command=6'b100011, then store 6'b101011 -> first passes MEM then WB; second takes MEM to FETCH with no write_enable; instr_count=2.
- Branch: exec_command=6'b000100 -> after exec_done goes straight to FETCH; no mem/write pulse; instr_count increments by 1.
- Halt: exec_command=6'b111111 -> no exec_enable; halted=1, state=6; instr_count unchanged; clear -> state=0 and counters 0.
- Watchdog: TIMEOUT=8, mem_done never asserted -> ERR after 8 wait cycles, err_stage=4, error=1. Second run asserts done in the timeout cycle -> no error.
- Ignored/async events: done during the enable cycle or from an idle stage causes no transition. rstn low mid-EXEC -> all outputs zero asynchronously; start after release restarts at FETCH.
